// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences an ARRAY_N x ARRAY_N int8 MAC grid.
// A job clears the PE accumulators, then feeds diagonally skewed
// reads into the west (A) and north (B) operand buffers. It waits
// for the wavefront to drain through the grid, then steps a row
// select so the result buffer can capture each PE row.
//
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   start, k_len  job strobe (accepted only in IDLE) and reduction depth
//   abort         synchronous cancel back to IDLE, no done issued
//   busy, done    status; done is a one-cycle pulse at job end
//   accum_reset   one-cycle clear pulse to every PE accumulator
//   lane_rd_en    per-lane operand read enable (west row i / north col i)
//   lane_rd_addr  per-lane read address, lane i at [i*K_WIDTH +: K_WIDTH]
//   lane_valid    lane_rd_en delayed one cycle (buffer read latency)
//   res_capture   result-buffer write strobe
//   res_row_sel   PE row being captured
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | accumulators cleared for one cycle
// FEED    | skewed operand reads, t = 0 .. k_len+ARRAY_N-2
// DRAIN   | ARRAY_N cycles for the wavefront to reach PE(N-1,N-1)
// READOUT | ARRAY_N cycles of row capture
// DONE    | one-cycle completion pulse
module systolic_ctrl #(
    parameter int ARRAY_N = 4,
    parameter int K_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [K_WIDTH-1:0]           k_len,
    output logic                         busy,
    output logic                         done,
    output logic                         accum_reset,
    output logic [ARRAY_N-1:0]           lane_rd_en,
    output logic [ARRAY_N*K_WIDTH-1:0]   lane_rd_addr,
    output logic [ARRAY_N-1:0]           lane_valid,
    output logic                         res_capture,
    output logic [$clog2(ARRAY_N)-1:0]   res_row_sel
);

    // One extra bit so k_len at its maximum plus the lane skew cannot wrap.
    localparam int TW = K_WIDTH + 1;
    localparam int CW = $clog2(ARRAY_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_READOUT,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [TW-1:0]        t, t_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [K_WIDTH-1:0]   k_reg, k_nxt;
    logic [TW-1:0]        last_t;
    logic [TW:0]          lane_t;

    logic                         busy_nxt;
    logic                         done_nxt;
    logic                         accum_reset_nxt;
    logic [ARRAY_N-1:0]           rd_en_nxt;
    logic [ARRAY_N*K_WIDTH-1:0]   rd_addr_nxt;
    logic                         res_capture_nxt;
    logic [CW-1:0]                res_row_sel_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            t            <= '0;
            cnt          <= '0;
            k_reg        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            accum_reset  <= 1'b0;
            lane_rd_en   <= '0;
            lane_rd_addr <= '0;
            lane_valid   <= '0;
            res_capture  <= 1'b0;
            res_row_sel  <= '0;
        end else begin
            state        <= state_nxt;
            t            <= t_nxt;
            cnt          <= cnt_nxt;
            k_reg        <= k_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            accum_reset  <= accum_reset_nxt;
            lane_rd_en   <= rd_en_nxt;
            lane_rd_addr <= rd_addr_nxt;
            // Reads already issued are dropped on abort as well.
            lane_valid   <= abort ? '0 : lane_rd_en;
            res_capture  <= res_capture_nxt;
            res_row_sel  <= res_row_sel_nxt;
        end
    end

    // Outputs are computed from the next state so they are registered
    // together with it (Moore outputs, no extra cycle of latency).
    always_comb begin
        state_nxt       = state;
        t_nxt           = t;
        cnt_nxt         = cnt;
        k_nxt           = k_reg;
        last_t          = {1'b0, k_reg} + TW'(ARRAY_N - 2);
        lane_t          = '0;
        busy_nxt        = 1'b0;
        done_nxt        = 1'b0;
        accum_reset_nxt = 1'b0;
        rd_en_nxt       = '0;
        rd_addr_nxt     = '0;
        res_capture_nxt = 1'b0;
        res_row_sel_nxt = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    k_nxt     = k_len;
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                t_nxt     = '0;
                cnt_nxt   = '0;
                state_nxt = (k_reg != '0) ? S_FEED : S_READOUT;
            end
            S_FEED: begin
                if (t == last_t) begin
                    cnt_nxt   = '0;
                    state_nxt = S_DRAIN;
                end else begin
                    t_nxt = t + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == CW'(ARRAY_N - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_READOUT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_READOUT: begin
                if (cnt == CW'(ARRAY_N - 1)) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (abort) begin
            state_nxt = S_IDLE;
        end

        busy_nxt        = (state_nxt != S_IDLE);
        accum_reset_nxt = (state_nxt == S_CLEAR);
        done_nxt        = (state_nxt == S_DONE);
        res_capture_nxt = (state_nxt == S_READOUT);
        if (state_nxt == S_READOUT) begin
            res_row_sel_nxt = cnt_nxt;
        end

        // Lane i lags lane 0 by i cycles. The top bit of lane_t is the
        // borrow of t-i, so lanes not yet started never form an address.
        if (state_nxt == S_FEED) begin
            for (int i = 0; i < ARRAY_N; i++) begin
                lane_t = {1'b0, t_nxt} - (TW + 1)'(i);
                if (!lane_t[TW] && (lane_t[TW-1:0] < {1'b0, k_reg})) begin
                    rd_en_nxt[i] = 1'b1;
                    rd_addr_nxt[i*K_WIDTH +: K_WIDTH] = K_WIDTH'(lane_t[TW-1:0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;

    localparam int N  = 4;
    localparam int KW = 16;
    localparam int KM = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [KW-1:0]      k_len;
    logic               busy;
    logic               done;
    logic               accum_reset;
    logic [N-1:0]       lane_rd_en;
    logic [N*KW-1:0]    lane_rd_addr;
    logic [N-1:0]       lane_valid;
    logic               res_capture;
    logic [1:0]         res_row_sel;

    int total = 0;
    int bad   = 0;

    systolic_ctrl #(.ARRAY_N(N), .K_WIDTH(KW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .k_len        (k_len),
        .busy         (busy),
        .done         (done),
        .accum_reset  (accum_reset),
        .lane_rd_en   (lane_rd_en),
        .lane_rd_addr (lane_rd_addr),
        .lane_valid   (lane_valid),
        .res_capture  (res_capture),
        .res_row_sel  (res_row_sel)
    );

    always #5 clk = ~clk;

    // Operand buffers plus a 4x4 systolic PE grid driven by the controller.
    logic signed [7:0] a_mem [N][KM];
    logic signed [7:0] b_mem [KM][N];
    logic signed [7:0] a_dat [N];
    logic signed [7:0] b_dat [N];
    logic signed [7:0] a_pe  [N][N];
    logic signed [7:0] b_pe  [N][N];
    logic              av_pe [N][N];
    logic              bv_pe [N][N];
    logic signed [7:0] a_in  [N][N];
    logic signed [7:0] b_in  [N][N];
    logic              av_in [N][N];
    logic              bv_in [N][N];
    int                acc   [N][N];
    int                cap   [N][N];

    always_comb begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_in[r][c]  = '0;
                b_in[r][c]  = '0;
                av_in[r][c] = 1'b0;
                bv_in[r][c] = 1'b0;
            end
        end
        for (int r = 0; r < N; r++) begin
            a_in[r][0]  = a_dat[r];
            av_in[r][0] = lane_valid[r];
            for (int c = 1; c < N; c++) begin
                a_in[r][c]  = a_pe[r][c-1];
                av_in[r][c] = av_pe[r][c-1];
            end
        end
        for (int c = 0; c < N; c++) begin
            b_in[0][c]  = b_dat[c];
            bv_in[0][c] = lane_valid[c];
            for (int r = 1; r < N; r++) begin
                b_in[r][c]  = b_pe[r-1][c];
                bv_in[r][c] = bv_pe[r-1][c];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (lane_rd_en[i]) begin
                if (int'(lane_rd_addr[i*KW +: KW]) < KM) begin
                    a_dat[i] <= a_mem[i][lane_rd_addr[i*KW +: KW]];
                    b_dat[i] <= b_mem[lane_rd_addr[i*KW +: KW]][i];
                end else begin
                    a_dat[i] <= '0;
                    b_dat[i] <= '0;
                end
            end
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_pe[r][c]  <= a_in[r][c];
                b_pe[r][c]  <= b_in[r][c];
                av_pe[r][c] <= av_in[r][c];
                bv_pe[r][c] <= bv_in[r][c];
                if (accum_reset)
                    acc[r][c] <= 0;
                else if (av_in[r][c] && bv_in[r][c])
                    acc[r][c] <= acc[r][c] + int'(a_in[r][c]) * int'(b_in[r][c]);
            end
        end
        if (res_capture) begin
            for (int c = 0; c < N; c++) begin
                cap[res_row_sel][c] <= acc[res_row_sel][c];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane i reads in cycles 2+i .. 1+i+k after the start edge, address p-2-i.
    function automatic logic [N-1:0] exp_en(input int p, input int k);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (k > 0 && p >= 2 + i && p <= 1 + i + k) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [N*KW-1:0] exp_addr(input int p, input int k);
        logic [N*KW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (k > 0 && p >= 2 + i && p <= 1 + i + k) r[i*KW +: KW] = KW'(p - 2 - i);
        return r;
    endfunction

    // Runs one job (two back-to-back jobs when start is held) and checks
    // every output in every cycle against the cycle-numbered timeline.
    task automatic run_job(input int k, input bit held);
        int dc, rs, per, ncyc, p, pp;
        dc   = (k > 0) ? k + 3 * N + 1 : N + 2;
        rs   = (k > 0) ? k + 2 * N + 1 : 2;
        per  = dc + 1;
        ncyc = held ? 2 * per : per;
        start = 1'b1;
        k_len = KW'(k);
        tick();
        if (!held) start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            p  = c % per;
            pp = (c - 1) % per;
            chk($sformatf("k%0d busy c%0d", k, c), 64'(busy), 64'(p >= 1 && p <= dc));
            chk($sformatf("k%0d accum_reset c%0d", k, c), 64'(accum_reset), 64'(p == 1));
            chk($sformatf("k%0d rd_en c%0d", k, c), 64'(lane_rd_en), 64'(exp_en(p, k)));
            chk($sformatf("k%0d rd_addr c%0d", k, c), 64'(lane_rd_addr), 64'(exp_addr(p, k)));
            chk($sformatf("k%0d valid c%0d", k, c), 64'(lane_valid), 64'(exp_en(pp, k)));
            chk($sformatf("k%0d capture c%0d", k, c), 64'(res_capture),
                64'(p >= rs && p < rs + N));
            chk($sformatf("k%0d row_sel c%0d", k, c), 64'(res_row_sel),
                (p >= rs && p < rs + N) ? 64'(p - rs) : 64'd0);
            chk($sformatf("k%0d done c%0d", k, c), 64'(done), 64'(p == dc));
            if (c < ncyc) tick();
        end
        start = 1'b0;
    endtask

    task automatic mat_test(input int mode);
        int expv;
        for (int r = 0; r < N; r++)
            for (int k = 0; k < KM; k++)
                a_mem[r][k] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'($urandom);
        for (int k = 0; k < KM; k++)
            for (int c = 0; c < N; c++)
                b_mem[k][c] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'($urandom);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                cap[r][c] = 32'h5A5A5A5A;
        run_job(KM, 1'b0);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                expv = 0;
                for (int k = 0; k < KM; k++)
                    expv += int'(a_mem[r][k]) * int'(b_mem[k][c]);
                chk($sformatf("mat%0d r%0d c%0d", mode, r, c), 64'(cap[r][c]), 64'(expv));
            end
        end
    endtask

    initial begin
        bit seen_done;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        k_len = '0;
        tick();
        tick();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset accum_reset", 64'(accum_reset), 64'd0);
        chk("reset rd_en", 64'(lane_rd_en), 64'd0);
        chk("reset rd_addr", 64'(lane_rd_addr), 64'd0);
        chk("reset valid", 64'(lane_valid), 64'd0);
        chk("reset capture", 64'(res_capture), 64'd0);
        chk("reset row_sel", 64'(res_row_sel), 64'd0);
        rst = 1'b0;
        tick();

        // Directed timelines.
        run_job(3, 1'b0);
        tick();
        run_job(0, 1'b0);
        tick();
        run_job(1, 1'b0);
        tick();

        // Reference PE grid: zeros, all 0xFF, random.
        mat_test(0);
        tick();
        mat_test(1);
        tick();
        mat_test(2);
        tick();
        mat_test(2);
        tick();

        // abort wins over start in IDLE.
        start = 1'b1;
        abort = 1'b1;
        k_len = 16'd3;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort vs start busy", 64'(busy), 64'd0);
        chk("abort vs start accum_reset", 64'(accum_reset), 64'd0);
        tick();

        // abort in cycle 4 of a k_len=8 job.
        start = 1'b1;
        k_len = 16'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort pre rd_en c4", 64'(lane_rd_en), 64'h7);
        chk("abort pre busy c4", 64'(busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort rd_en", 64'(lane_rd_en), 64'd0);
        chk("abort rd_addr", 64'(lane_rd_addr), 64'd0);
        chk("abort valid", 64'(lane_valid), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) seen_done = 1'b1;
            tick();
        end
        chk("abort no done later", 64'(seen_done), 64'd0);
        run_job(3, 1'b0);
        tick();

        // start held high: back-to-back jobs, start during FEED ignored.
        run_job(2, 1'b1);
        tick();
        tick();
        chk("held released busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of FEED.
        start = 1'b1;
        k_len = 16'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("rst pre rd_en c4", 64'(lane_rd_en), 64'h7);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst rd_en", 64'(lane_rd_en), 64'd0);
        chk("async rst rd_addr", 64'(lane_rd_addr), 64'd0);
        chk("async rst valid", 64'(lane_valid), 64'd0);
        chk("async rst done", 64'(done), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        chk("after rst busy", 64'(busy), 64'd0);
        run_job(2, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for an ARRAY_N x ARRAY_N grid of int8 multiply-accumulate PEs. On `start` it clears the PE accumulators and drives per-lane, diagonally skewed read enables/addresses into the west (A) and north (B) operand buffers. It issues per-lane valids aligned to the buffers' 1-cycle read latency, waits for the wavefront to drain through the grid, then steps a row-select to capture accumulated results. It sits between the host/DMA command interface and the PE grid plus its operand and result buffers.

## Interface
- ARRAY_N, 4, grid dimension (rows = columns = lanes), ≥ 2
- K_WIDTH, 16, width of reduction length and per-lane buffer address
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  command strobe; sampled only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE from any state
- k_len  input  K_WIDTH  reduction depth K; sampled with `start`
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on job completion
- accum_reset  output  1  one-cycle pulse to all PE accumulators
- lane_rd_en  output  ARRAY_N  operand-buffer read enable per lane; lane i drives both west row i and north column i
- lane_rd_addr  output  ARRAY_N*K_WIDTH  per-lane address, lane i at [i*K_WIDTH +: K_WIDTH]
- lane_valid  output  ARRAY_N  lane_rd_en delayed 1 cycle; PE-edge valid for row i / column i
- res_capture  output  1  result-buffer write strobe
- res_row_sel  output  clog2(ARRAY_N)  PE row being captured

## Operation
- All outputs are registered (Moore). Reset value of every output is 0. State resets to IDLE and counters to 0.
- States: IDLE, CLEAR, FEED, DRAIN, READOUT, DONE.
- IDLE: `start`=1 latches k_len, then goes to CLEAR. `start` outside IDLE is ignored.
- CLEAR (1 cycle): accum_reset=1. Next state is FEED if k_len≠0, else READOUT (results are zero).
- FEED: counter t runs 0 … k_len+ARRAY_N−2, so FEED lasts k_len+ARRAY_N−1 cycles.
  - lane_rd_en[i] = (t ≥ i) && (t−i < k_len).
  - lane_rd_addr lane i = t−i when enabled, else 0.
  - On the last t, go to DRAIN.
- DRAIN (ARRAY_N cycles): no reads. lane_valid still emits the final registered enables in the first DRAIN cycle.
- READOUT (ARRAY_N cycles): res_capture=1 and res_row_sel = 0,1,…,ARRAY_N−1. Then go to DONE.
- DONE (1 cycle): done=1, then go to IDLE. `start` is not accepted in DONE; it is accepted in the following IDLE cycle.
- abort=1: next state is IDLE. All strobes and enables go to 0 on that edge and no done is issued. abort has priority over every transition, including `start` in IDLE.
- Arithmetic:
  - t is K_WIDTH+1 bits wide, so k_len = 2^K_WIDTH−1 with ARRAY_N−1 skew does not wrap.
  - t−i is computed only under the enable condition, so no negative address is ever output.
- Skew rationale: row r / column c elements arrive at PE(r,c) after c / r register stages. Matching lane skew i therefore aligns operand k at every PE at cycle k+r+c after the lane-0 first read.

## Timing
- `start` sampled at edge E0: accum_reset is high in cycle 1 and FEED occupies cycles 2 … k_len+ARRAY_N.
- The last lane_valid of lane ARRAY_N−1 is in the first DRAIN cycle. PE(N−1,N−1) performs its last accumulate at the end of the last DRAIN cycle.
- Results are stable from the first READOUT cycle, and the result buffer writes row res_row_sel on each res_capture edge.
- Total for k_len≥1: done asserts in cycle k_len+3·ARRAY_N+1 after E0; busy is high from cycle 1 through that cycle.
- For k_len=0: CLEAR in cycle 1, READOUT in cycles 2 … ARRAY_N+1, done in cycle ARRAY_N+2.
- Asynchronous rst mid-job: all outputs are 0 immediately. The first legal `start` is at the first edge after rst deasserts.

## Test plan
- ARRAY_N=4, k_len=3, start at E0:
  - accum_reset in cycle 1 only.
  - lane0 rd_en in cycles 2–4 (addr 0,1,2); lane3 rd_en in cycles 5–7 (addr 0,1,2).
  - lane_valid equals rd_en shifted +1.
  - res_capture in cycles 12–15 with sel 0–3; done in cycle 16.
- k_len=0: accum_reset in cycle 1, lane_rd_en never asserts, res_capture in cycles 2–5, done in cycle 6.
- Full reference model: drive the controller into a 4x4 PE model with random int8 A(4x5), B(5x4). The captured rows must equal A·B with 32-bit accumulation, checking both all-0x00 and all-0xFF operands.
- abort in cycle 4 of a k_len=8 job: all enables drop at the next edge, no done, busy=0. A new start then completes normally.
- start held high continuously: back-to-back jobs, with the second CLEAR in the cycle after the DONE-following IDLE. start during FEED is ignored.
- rst asserted asynchronously mid-FEED: outputs are 0 before the next edge and the state is IDLE after release.
